// File: rtl/ibuf_lvl3.sv
// Instruction buffer sitting between fetch and a single execute unit.
// Instructions bypass straight to execute when the buffer is empty and
// execute can take them; otherwise they queue in a circular FIFO. Long
// instructions occupy execute for LONG_CYCLES cycles, short ones for one.
module ibuf_lvl3 #(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 32,
    parameter int LONG_CYCLES  = 3,
    parameter int STALL_THRESH = DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_in_valid,
    input  logic [DATA_W-1:0]          instr_in_data,
    input  logic                       instr_is_long,
    input  logic                       flush,
    output logic                       instr_in_stall,
    output logic                       exec_issue_valid,
    output logic [DATA_W-1:0]          exec_issue_data,
    output logic                       exec_issue_long,
    output logic                       exec_busy,
    output logic                       exec_will_free_next,
    output logic                       bypass_allowed,
    output logic                       push_allowed,
    output logic                       pop_allowed,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] max_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Each entry is {long flag, instruction word}
    logic [DATA_W:0]   mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [3:0]        busy_cnt;
    logic [DATA_W-1:0] last_data;
    logic              last_long;
    logic              exec_can_accept;
    logic [CW-1:0]     count_next;

    // Circular pointer advance; DEPTH need not be a power of two
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign exec_busy           = (busy_cnt != 4'd0);
    assign exec_will_free_next = (busy_cnt == 4'd1);
    assign exec_can_accept     = !exec_busy || exec_will_free_next;

    // Per-cycle accept / issue decisions, all from registered state and inputs
    always_comb begin
        instr_in_stall   = (count >= CW'(STALL_THRESH)) || flush;
        bypass_allowed   = instr_in_valid && !instr_in_stall && (count == '0) && exec_can_accept;
        push_allowed     = instr_in_valid && !instr_in_stall && !bypass_allowed;
        pop_allowed      = (count != '0) && exec_can_accept && !flush;
        exec_issue_valid = bypass_allowed || pop_allowed;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push_allowed) - CW'(pop_allowed);
        end
    end

    // Issue word: input on bypass, FIFO head on pop, otherwise the last issued word
    always_comb begin
        exec_issue_data = last_data;
        exec_issue_long = last_long;
        if (bypass_allowed) begin
            exec_issue_data = instr_in_data;
            exec_issue_long = instr_is_long;
        end else if (pop_allowed) begin
            {exec_issue_long, exec_issue_data} = mem[rd_ptr];
        end
    end

    // Control state: pointers, occupancy, watermark, execute occupancy, held issue word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
            busy_cnt  <= '0;
            last_data <= '0;
            last_long <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_allowed) begin
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop_allowed) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
            end
            count <= count_next;
            if (count_next > max_count) begin
                max_count <= count_next;
            end
            // Flush leaves execute occupancy alone; it only empties the buffer
            if (exec_issue_valid) begin
                busy_cnt  <= exec_issue_long ? 4'(LONG_CYCLES) : 4'd1;
                last_data <= exec_issue_data;
                last_long <= exec_issue_long;
            end else if (busy_cnt != 4'd0) begin
                busy_cnt <= busy_cnt - 4'd1;
            end
        end
    end

    // Storage array: written on push only, contents need no reset
    always_ff @(posedge clk) begin
        if (push_allowed) begin
            mem[wr_ptr] <= {instr_is_long, instr_in_data};
        end
    end

endmodule

// File: tb/tb_ibuf_lvl3.sv
// Bench for ibuf_lvl3 (DEPTH=3 so pointer wrap is non-power-of-two).
// Reference model: a queue of buffered entries plus the cycle number at
// which execute next becomes able to accept.
module tb_ibuf_lvl3;

    localparam int DEPTH = 3;
    localparam int DW    = 32;
    localparam int L     = 3;
    localparam int THR   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          instr_in_valid;
    logic [DW-1:0] instr_in_data;
    logic          instr_is_long;
    logic          flush;
    logic          instr_in_stall;
    logic          exec_issue_valid;
    logic [DW-1:0] exec_issue_data;
    logic          exec_issue_long;
    logic          exec_busy;
    logic          exec_will_free_next;
    logic          bypass_allowed;
    logic          push_allowed;
    logic          pop_allowed;
    logic [CW-1:0] count;
    logic [CW-1:0] max_count;

    ibuf_lvl3 #(
        .DEPTH(DEPTH), .DATA_W(DW), .LONG_CYCLES(L), .STALL_THRESH(THR)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_in_valid(instr_in_valid), .instr_in_data(instr_in_data),
        .instr_is_long(instr_is_long), .flush(flush),
        .instr_in_stall(instr_in_stall), .exec_issue_valid(exec_issue_valid),
        .exec_issue_data(exec_issue_data), .exec_issue_long(exec_issue_long),
        .exec_busy(exec_busy), .exec_will_free_next(exec_will_free_next),
        .bypass_allowed(bypass_allowed), .push_allowed(push_allowed),
        .pop_allowed(pop_allowed), .count(count), .max_count(max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW:0]   q[$];
    longint        cyc;
    longint        free_at;
    int            mmax;
    logic [DW-1:0] last_d;
    logic          last_l;
    logic          e_can, e_stall, e_byp, e_push, e_pop, e_iv, e_l;
    logic [DW-1:0] e_d;

    task automatic model_reset();
        q.delete();
        cyc     = 0;
        free_at = -1;
        mmax    = 0;
        last_d  = '0;
        last_l  = 1'b0;
    endtask

    task automatic model_check();
        e_can   = (free_at <= cyc);
        e_stall = (q.size() >= THR) || flush;
        e_byp   = instr_in_valid && !e_stall && (q.size() == 0) && e_can;
        e_push  = instr_in_valid && !e_stall && !e_byp;
        e_pop   = (q.size() != 0) && e_can && !flush;
        e_iv    = e_byp || e_pop;
        e_d = last_d;
        e_l = last_l;
        if (e_byp) begin
            e_d = instr_in_data;
            e_l = instr_is_long;
        end else if (e_pop) begin
            {e_l, e_d} = q[0];
        end
        chk("count", count, q.size());
        chk("max_count", max_count, mmax);
        chk("stall", instr_in_stall, e_stall);
        chk("bypass", bypass_allowed, e_byp);
        chk("push", push_allowed, e_push);
        chk("pop", pop_allowed, e_pop);
        chk("issue_valid", exec_issue_valid, e_iv);
        chk("issue_data", exec_issue_data, e_d);
        chk("issue_long", exec_issue_long, e_l);
        chk("exec_busy", exec_busy, free_at >= cyc);
        chk("will_free", exec_will_free_next, free_at == cyc);
    endtask

    task automatic model_advance();
        if (e_iv) begin
            free_at = cyc + (e_l ? longint'(L) : 64'sd1);
            last_d  = e_d;
            last_l  = e_l;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_push) q.push_back({instr_is_long, instr_in_data});
        end
        if (q.size() > mmax) mmax = q.size();
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic lg, input logic fl);
        @(negedge clk);
        instr_in_valid = v;
        instr_in_data  = d;
        instr_is_long  = lg;
        flush          = fl;
        #1;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic lg, input logic fl);
        drive(v, d, lg, fl);
        model_check();
        model_advance();
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge
    task automatic do_reset(input int pre_cnt);
        @(negedge clk);
        instr_in_valid = 1'b0;
        instr_in_data  = '0;
        instr_is_long  = 1'b0;
        flush          = 1'b0;
        #1;
        if (pre_cnt >= 0) begin
            chk("pre_rst_count", count, pre_cnt);
            chk("pre_rst_busy", exec_busy, 1);
            chk("pre_rst_will_free", exec_will_free_next, 0);
        end
        #1 reset = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_max_count", max_count, 0);
        chk("rst_issue_valid", exec_issue_valid, 0);
        chk("rst_issue_data", exec_issue_data, 0);
        chk("rst_issue_long", exec_issue_long, 0);
        chk("rst_busy", exec_busy, 0);
        chk("rst_will_free", exec_will_free_next, 0);
        chk("rst_stall", instr_in_stall, 0);
        chk("rst_push", push_allowed, 0);
        chk("rst_pop", pop_allowed, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          lg;
        logic          fl;
        logic          byp;
        logic          psh;
        logic          pp;
        logic          iv;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
    } vec_t;

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic lg, logic byp, logic psh,
                                logic pp, logic iv, logic [DW-1:0] ed, logic [CW-1:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.lg = lg; r.fl = 1'b0;
        r.byp = byp; r.psh = psh; r.pp = pp; r.iv = iv; r.ed = ed; r.ec = ec;
        return r;
    endfunction

    vec_t tbl[16];
    logic saw_full;

    initial begin
        reset = 1'b0;
        instr_in_valid = 1'b0;
        instr_in_data  = '0;
        instr_is_long  = 1'b0;
        flush          = 1'b0;
        model_reset();

        // Five back-to-back shorts bypass, then long A followed by shorts B..G
        for (int i = 0; i < 5; i++)
            tbl[i] = mk(1, 32'h100 + i, 0, 1, 0, 0, 1, 32'h100 + i, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h104, 0);
        tbl[6]  = mk(1, 32'hA0, 1, 1, 0, 0, 1, 32'hA0, 0);
        tbl[7]  = mk(1, 32'hB0, 0, 0, 1, 0, 0, 32'hA0, 0);
        tbl[8]  = mk(1, 32'hC0, 0, 0, 1, 0, 0, 32'hA0, 1);
        tbl[9]  = mk(1, 32'hD0, 0, 0, 1, 1, 1, 32'hB0, 2);
        tbl[10] = mk(1, 32'hE0, 0, 0, 1, 1, 1, 32'hC0, 2);
        tbl[11] = mk(1, 32'hF0, 0, 0, 1, 1, 1, 32'hD0, 2);
        tbl[12] = mk(1, 32'h70, 0, 0, 1, 1, 1, 32'hE0, 2);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 32'hF0, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 1, 32'h70, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h70, 0);

        do_reset(-1);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].lg, tbl[i].fl);
            chk($sformatf("tbl%0d_bypass", i), bypass_allowed, tbl[i].byp);
            chk($sformatf("tbl%0d_push", i), push_allowed, tbl[i].psh);
            chk($sformatf("tbl%0d_pop", i), pop_allowed, tbl[i].pp);
            chk($sformatf("tbl%0d_issue_valid", i), exec_issue_valid, tbl[i].iv);
            chk($sformatf("tbl%0d_issue_data", i), exec_issue_data, tbl[i].ed);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
            model_check();
            model_advance();
        end
        chk("seq_max_count", max_count, 2);

        // Execute held by continuous longs: buffer fills and input stalls
        do_reset(-1);
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'hC00 + i, 1, 0);
            if (count == CW'(DEPTH)) begin
                saw_full = 1'b1;
                chk("full_stall", instr_in_stall, 1);
                chk("full_no_push", push_allowed, 0);
            end
            model_check();
            model_advance();
        end
        chk("reached_full", saw_full, 1);

        // Keep feeding longs until the buffer will hold DEPTH entries, then flush
        for (int i = 0; i < 10 && q.size() != DEPTH; i++)
            step(1, 32'hD00 + i, 1, 0);
        drive(1, 32'hDEAD, 0, 1);
        chk("flush_pre_count", count, DEPTH);
        chk("flush_no_pop", pop_allowed, 0);
        chk("flush_no_issue", exec_issue_valid, 0);
        chk("flush_stall", instr_in_stall, 1);
        model_check();
        model_advance();
        drive(0, 0, 0, 0);
        chk("flush_post_count", count, 0);
        chk("flush_max_kept", max_count, DEPTH);
        model_check();
        model_advance();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset mid-cycle while holding two entries and execute occupied
        do_reset(-1);
        step(1, 32'h1A, 1, 0);
        step(1, 32'h1B, 1, 0);
        step(1, 32'h1C, 0, 0);
        step(1, 32'h1D, 0, 0);
        step(0, 0, 0, 0);
        do_reset(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Randomized traffic against the model, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(-1);
            step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibuf_lvl3.md
IBUF_LVL3 -- requirements
Module: ibuf_lvl3

Interface
REQ-001 Parameter DEPTH, default 4: buffer entries; legal range 2..16, and DEPTH need not be a power of two.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Parameter LONG_CYCLES, default 3: execute occupancy of a long instruction; legal range 2..15.
REQ-004 Parameter STALL_THRESH, default DEPTH: occupancy at which input stall asserts; legal range 1..DEPTH.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 instr_in_valid  in  1  upstream instruction present.
REQ-008 instr_in_data  in  DATA_W  upstream instruction word.
REQ-009 instr_is_long  in  1  upstream instruction is multi-cycle; meaningful only with instr_in_valid.
REQ-010 flush  in  1  discard all buffered entries.
REQ-011 instr_in_stall  out  1  upstream must hold; the input is not accepted this cycle.
REQ-012 exec_issue_valid  out  1  instruction issued to execute this cycle.
REQ-013 exec_issue_data  out  DATA_W  issued instruction word.
REQ-014 exec_issue_long  out  1  issued instruction is long.
REQ-015 exec_busy, exec_will_free_next  out  1 each  execute-occupancy status.
REQ-016 bypass_allowed, push_allowed, pop_allowed  out  1 each  per-cycle decision strobes.
REQ-017 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-018 max_count  out  $clog2(DEPTH+1)  high-watermark of count since reset.

Function
REQ-019 exec_can_accept SHALL be defined as (!exec_busy || exec_will_free_next).
REQ-020 instr_in_stall SHALL equal (count >= STALL_THRESH) || flush, combinationally from registered count.
REQ-021 bypass_allowed SHALL equal instr_in_valid && !instr_in_stall && count==0 && exec_can_accept.
REQ-022 push_allowed SHALL equal instr_in_valid && !instr_in_stall && !bypass_allowed.
REQ-023 pop_allowed SHALL equal count!=0 && exec_can_accept && !flush.
REQ-024 exec_issue_valid SHALL equal bypass_allowed || pop_allowed; these two terms are mutually exclusive by construction.
REQ-025 On bypass, exec_issue_data/exec_issue_long SHALL be the input fields; on pop, they SHALL be the head entry; with no issue, data holds its last value.
REQ-026 Each entry SHALL store {instr_is_long, instr_in_data}.
REQ-027 Push writes at the write pointer; pop reads at the read pointer. Each pointer increments and wraps from DEPTH-1 to 0.
REQ-028 count next = count + push_allowed - pop_allowed; simultaneous push and pop leave count unchanged.
REQ-029 Order SHALL be strict FIFO; bypass never overtakes a buffered entry.
REQ-030 busy_cnt (4-bit) on issue: load LONG_CYCLES if the issued instruction is long, else load 1.
REQ-031 busy_cnt with no issue: decrement if nonzero.
REQ-032 exec_busy = (busy_cnt != 0); exec_will_free_next = (busy_cnt == 1).
REQ-033 A long instruction issued at cycle t SHALL block the next issue until cycle t+LONG_CYCLES.
REQ-034 Short instructions SHALL issue back-to-back every cycle.
REQ-035 Flush SHALL clear count and both pointers at the next edge, and SHALL drop the input offered in the flush cycle.
REQ-036 Flush SHALL NOT alter busy_cnt or max_count.
REQ-037 max_count SHALL update to count_next whenever count_next > max_count.
REQ-038 count SHALL never exceed DEPTH; count==DEPTH implies instr_in_stall.

Reset
REQ-039 On reset assertion, outputs and state SHALL clear immediately, regardless of clk: count, max_count, pointers, busy_cnt = 0, and exec_issue_data = 0.
REQ-040 Reset asserted mid-operation SHALL discard all entries and any execute occupancy.
REQ-041 Storage array contents need no reset.
REQ-042 First push or bypass is permitted on the first rising edge after reset deasserts.

Verification
REQ-043 Idle and empty, 5 short instructions on consecutive cycles -> bypass_allowed=1 each cycle, count stays 0, exec_issue_valid=1 for 5 cycles.
REQ-044 Long instruction A, then shorts B–G continuously, LONG_CYCLES=3, DEPTH=4 -> A issued at t, B at t+3, count peaks at 2, max_count=2, order A..G preserved.
REQ-045 Exec held busy by long instructions while input is continuous -> count reaches DEPTH, instr_in_stall=1, and no push occurs at count==DEPTH.
REQ-046 DEPTH=3 with 10 push/pop cycles -> pointers wrap correctly and data emerges in order.
REQ-047 flush with count=3 -> count=0 next cycle, no pop in the flush cycle, busy_cnt unchanged, max_count retained.
REQ-048 reset asserted between edges with count=2 and busy_cnt=2 -> all outputs 0 immediately, before the next clk edge.
